// File: rtl/ps2_pkg.sv
// Shared PS/2 types and constants for the host-side transmitter and receiver.
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RTS,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_ACK,
        ST_WAIT_REL
    } ps2_tx_state_t;

    // 120 us inhibit, 8-tap glitch filter, 15 ms device-clocked limit at 50 MHz
    localparam int PS2_INHIBIT_CYCLES = 6000;
    localparam int PS2_FILTER_LEN     = 8;
    localparam int PS2_TIMEOUT_CYCLES = 750000;

    localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
    localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] PS2_RESP_ACK     = 8'hFA;

    // Frame payload as shifted out: data LSB-first followed by odd parity
    function automatic logic [8:0] ps2_frame(input logic [7:0] b);
        return {~^b, b};
    endfunction

endpackage

// File: rtl/ps2_edge_filter.sv
// Synchronizes the PS/2 pins and produces a glitch-filtered falling-edge tick
// on the clock line. FILTER_LEN must be at least 2.
module ps2_edge_filter
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN = PS2_FILTER_LEN
) (
    input  logic clk,
    input  logic resetn,
    input  logic ps2c_pin,
    input  logic ps2d_pin,
    output logic c_sync,
    output logic d_sync,
    output logic fall
);

    logic [1:0]            c_meta;
    logic [1:0]            d_meta;
    logic [FILTER_LEN-1:0] taps;
    logic                  level;

    // Two-flop synchronizers; reset high so an idle bus looks released
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            c_meta <= 2'b11;
            d_meta <= 2'b11;
        end else begin
            c_meta <= {c_meta[0], ps2c_pin};
            d_meta <= {d_meta[0], ps2d_pin};
        end
    end

    assign c_sync = c_meta[1];
    assign d_sync = d_meta[1];

    // Level only changes on a full run of equal taps; fall marks its 1->0 edge
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            taps  <= '1;
            level <= 1'b1;
            fall  <= 1'b0;
        end else begin
            taps <= {taps[FILTER_LEN-2:0], c_meta[1]};
            if (&taps)
                level <= 1'b1;
            else if (~|taps)
                level <= 1'b0;
            fall <= level & ~|taps;
        end
    end

endmodule

// File: rtl/ps2_tx.sv
// Host-to-device PS/2 command transmitter: request-to-send, start, 8 data bits
// LSB-first, odd parity, stop, then the device acknowledge.
module ps2_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = PS2_INHIBIT_CYCLES,
    parameter int FILTER_LEN     = PS2_FILTER_LEN,
    parameter int TIMEOUT_CYCLES = PS2_TIMEOUT_CYCLES
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       wr_ps2,
    input  logic [7:0] din,
    inout  wire        ps2c,
    inout  wire        ps2d,
    output logic       tx_idle,
    output logic       tx_done_tick,
    output logic       tx_err_tick
);

    localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    ps2_tx_state_t    state, state_n;
    logic [8:0]       sh, sh_n;
    logic [3:0]       n, n_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             done_n, err_n;
    logic             c_low, d_low;
    logic             c_sync, d_sync, fall;

    ps2_edge_filter #(.FILTER_LEN(FILTER_LEN)) u_filt (
        .clk      (clk),
        .resetn   (resetn),
        .ps2c_pin (ps2c),
        .ps2d_pin (ps2d),
        .c_sync   (c_sync),
        .d_sync   (d_sync),
        .fall     (fall)
    );

    // Open-drain pins; drive enables come straight from reset-cleared state
    assign ps2c    = c_low ? 1'b0 : 1'bz;
    assign ps2d    = d_low ? 1'b0 : 1'bz;
    assign tx_idle = (state == ST_IDLE);

    // State, datapath and registered completion ticks
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= ST_IDLE;
            sh           <= '0;
            n            <= '0;
            cnt          <= '0;
            tx_done_tick <= 1'b0;
            tx_err_tick  <= 1'b0;
        end else begin
            state        <= state_n;
            sh           <= sh_n;
            n            <= n_n;
            cnt          <= cnt_n;
            tx_done_tick <= done_n;
            tx_err_tick  <= err_n;
        end
    end

    // Next state, line drives and tick requests; timeout overrides everything
    always_comb begin
        state_n = state;
        sh_n    = sh;
        n_n     = n;
        cnt_n   = cnt;
        done_n  = 1'b0;
        err_n   = 1'b0;
        c_low   = 1'b0;
        d_low   = 1'b0;

        case (state)
            ST_IDLE: begin
                if (wr_ps2) begin
                    sh_n    = ps2_frame(din);
                    n_n     = 4'd8;
                    cnt_n   = CNT_W'(INHIBIT_CYCLES - 1);
                    state_n = ST_RTS;
                end
            end
            ST_RTS: begin
                c_low = 1'b1;
                d_low = 1'b1;
                if (cnt == '0) begin
                    cnt_n   = CNT_W'(TIMEOUT_CYCLES - 1);
                    state_n = ST_START;
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            ST_START: begin
                d_low = 1'b1;
                if (fall)
                    state_n = ST_DATA;
            end
            ST_DATA: begin
                d_low = ~sh[0];
                if (fall) begin
                    sh_n = {1'b0, sh[8:1]};
                    if (n == 4'd0)
                        state_n = ST_STOP;
                    else
                        n_n = n - 4'd1;
                end
            end
            ST_STOP: begin
                if (fall)
                    state_n = ST_ACK;
            end
            ST_ACK: begin
                if (fall) begin
                    if (!d_sync) begin
                        state_n = ST_WAIT_REL;
                    end else begin
                        err_n   = 1'b1;
                        state_n = ST_IDLE;
                    end
                end
            end
            ST_WAIT_REL: begin
                if (c_sync && d_sync) begin
                    done_n  = 1'b1;
                    state_n = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase

        // Device-clocked phase is bounded; expiry wins over a same-cycle fall
        if (state inside {ST_START, ST_DATA, ST_STOP, ST_ACK, ST_WAIT_REL}) begin
            cnt_n = cnt - CNT_W'(1);
            if (cnt == '0) begin
                sh_n    = sh;
                n_n     = n;
                done_n  = 1'b0;
                err_n   = 1'b1;
                state_n = ST_IDLE;
            end
        end
    end

endmodule

// File: tb/tb_ps2_tx.sv
// Directed bench for ps2_tx with a clocking-device model and a bit scoreboard.
module tb_ps2_tx;
    import ps2_pkg::*;

    localparam int INH = 200;
    localparam int FL  = 8;
    localparam int TO  = 2000;
    localparam int H   = 50;   // device half clock period in system cycles

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       wr_ps2 = 1'b0;
    logic [7:0] din = 8'h00;
    logic       dev_c_low = 1'b0;
    logic       dev_d_low = 1'b0;
    logic       tx_idle, tx_done_tick, tx_err_tick;
    wire        ps2c, ps2d;

    assign ps2c = dev_c_low ? 1'b0 : 1'bz;
    assign ps2d = dev_d_low ? 1'b0 : 1'bz;
    pullup (ps2c);
    pullup (ps2d);

    int total = 0, bad = 0;
    int cyc = 0, done_cnt = 0, err_cnt = 0;
    int exp_done = 0, exp_err = 0;
    int t0 = 0, t1 = 0, t2 = 0, rel_cyc = 0;
    bit exp_q[$];

    ps2_tx #(.INHIBIT_CYCLES(INH), .FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .wr_ps2       (wr_ps2),
        .din          (din),
        .ps2c         (ps2c),
        .ps2d         (ps2d),
        .tx_idle      (tx_idle),
        .tx_done_tick (tx_done_tick),
        .tx_err_tick  (tx_err_tick)
    );

    always #10 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (tx_done_tick) done_cnt <= done_cnt + 1;
        if (tx_err_tick)  err_cnt  <= err_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wait_cycles(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic push_frame(input logic [7:0] b);
        exp_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) exp_q.push_back(b[i]);
        exp_q.push_back(~^b);
        exp_q.push_back(1'b1);
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        din = b;
        wr_ps2 = 1'b1;
        @(negedge clk);
        wr_ps2 = 1'b0;
    endtask

    task automatic wait_release();
        int k = 0;
        while (ps2c !== 1'b1 && k < INH + 50) begin
            @(negedge clk);
            k++;
        end
        rel_cyc = cyc;
        check("rts_release", ps2c, 1'b1);
    endtask

    // Device: samples the data line just before each falling clock edge;
    // pulse 12 is the acknowledge pulse with data pulled low when ack=1.
    task automatic dev_xfer(input int npulses, input bit ack, input int glitch_pulse);
        bit e;
        wait_release();
        for (int i = 0; i < npulses; i++) begin
            if (i == 11) dev_d_low = ack;
            wait_cycles(H);
            if (i < 11) begin
                if (exp_q.size() == 0) begin
                    check("sb_underflow", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("frame_bit%0d", i), ps2d, e);
                end
            end
            dev_c_low = 1'b1;
            wait_cycles(H);
            dev_c_low = 1'b0;
            if (i == 11) dev_d_low = 1'b0;
            if (i == glitch_pulse) begin
                wait_cycles(20);
                dev_c_low = 1'b1;
                wait_cycles(5);
                dev_c_low = 1'b0;
            end
        end
    endtask

    task automatic wait_outcome(input string tag);
        int k = 0;
        while ((done_cnt != exp_done || err_cnt != exp_err) && k < 50) begin
            @(negedge clk);
            k++;
        end
        wait_cycles(3);
        check({tag, "_done_cnt"}, done_cnt, exp_done);
        check({tag, "_err_cnt"}, err_cnt, exp_err);
        check({tag, "_idle"}, tx_idle, 1'b1);
        check({tag, "_c_rel"}, ps2c, 1'b1);
        check({tag, "_d_rel"}, ps2d, 1'b1);
        check({tag, "_sb_empty"}, exp_q.size(), 0);
    endtask

    initial begin
        // reset state, and a strobe while held in reset is ignored
        wait_cycles(3);
        @(negedge clk); din = 8'h55; wr_ps2 = 1'b1;
        @(negedge clk); wr_ps2 = 1'b0;
        check("rst_idle", tx_idle, 1'b1);
        check("rst_c", ps2c, 1'b1);
        check("rst_d", ps2d, 1'b1);
        check("rst_done", tx_done_tick, 1'b0);
        check("rst_err", tx_err_tick, 1'b0);
        resetn = 1'b1;
        wait_cycles(20);
        check("post_rst_idle", tx_idle, 1'b1);
        check("post_rst_ticks", done_cnt + err_cnt, 0);

        // set-LEDs command with RTS length measured
        push_frame(PS2_CMD_SET_LEDS);
        exp_done++;
        send(PS2_CMD_SET_LEDS);
        t0 = cyc;
        check("rts_c_low", ps2c, 1'b0);
        check("rts_d_low", ps2d, 1'b0);
        check("rts_busy", tx_idle, 1'b0);
        dev_xfer(12, 1'b1, -1);
        check("rts_len", rel_cyc - t0, INH);
        wait_outcome("ed");

        // all-zero and all-one bytes both carry parity 1
        push_frame(8'h00); exp_done++; send(8'h00); dev_xfer(12, 1'b1, -1); wait_outcome("x00");
        push_frame(PS2_CMD_RESET); exp_done++; send(PS2_CMD_RESET); dev_xfer(12, 1'b1, -1); wait_outcome("xff");

        // device never clocks: error exactly TO cycles after clock release
        send(8'hA5);
        wait_release();
        t1 = rel_cyc;
        t2 = -1;
        for (int k = 0; k < TO + 50; k++) begin
            if (tx_err_tick === 1'b1) begin
                t2 = cyc;
                break;
            end
            @(negedge clk);
        end
        check("to_latency", t2 - t1, TO);
        check("to_c_rel", ps2c, 1'b1);
        check("to_d_rel", ps2d, 1'b1);
        check("to_idle", tx_idle, 1'b1);
        exp_err++;
        wait_outcome("timeout");

        // missing acknowledge
        push_frame(8'h3C); exp_err++; send(8'h3C); dev_xfer(12, 1'b0, -1); wait_outcome("nack");

        // strobe with a different byte during DATA is ignored
        push_frame(PS2_CMD_SET_LEDS);
        exp_done++;
        send(PS2_CMD_SET_LEDS);
        fork
            dev_xfer(12, 1'b1, -1);
            begin
                wait_cycles(INH + 4 * H);
                check("ign_busy", tx_idle, 1'b0);
                @(negedge clk); din = 8'h12; wr_ps2 = 1'b1;
                @(negedge clk); wr_ps2 = 1'b0;
            end
        join
        wait_outcome("ignore");

        // short clock glitch during DATA produces no shift (parity 0 byte)
        push_frame(8'h07); exp_done++; send(8'h07); dev_xfer(12, 1'b1, 3); wait_outcome("glitch");

        // reset mid-DATA releases both lines immediately
        push_frame(PS2_CMD_SET_LEDS);
        send(PS2_CMD_SET_LEDS);
        dev_xfer(2, 1'b1, -1);
        check("mid_d_driven", ps2d, 1'b0);
        #1 resetn = 1'b0;
        #1;
        check("mid_rst_c", ps2c, 1'b1);
        check("mid_rst_d", ps2d, 1'b1);
        check("mid_rst_idle", tx_idle, 1'b1);
        exp_q.delete();
        @(negedge clk); resetn = 1'b1;
        wait_cycles(30);
        check("mid_rst_done_cnt", done_cnt, exp_done);
        check("mid_rst_err_cnt", err_cnt, exp_err);
        check("mid_rst_still_idle", tx_idle, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
